// File: rtl/tick_timer_arb.sv
// Four-way round-robin arbiter sharing one tick prescaler and down-counter.
// Define TICK_TIMER_ARB_ABORT_EN to let an owner abandon its timer by dropping req.
module tick_timer_arb #(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ   = 1_000,
    parameter int TW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [4*TW-1:0] dur,
    output logic [3:0]    gnt,
    output logic [3:0]    done,
    output logic          busy,
    output logic [TW-1:0] remaining
);

    localparam int P  = CLK_HZ / FREQ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;

    logic [1:0] win, own, idx;
    logic       found, wrap, expire, owner_req;

    // First requester at or after the pointer, wrapping mod 4
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        own = '0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_q[i]) own = 2'(i);
        end
    end

    assign owner_req = |(req & gnt_q);
    assign wrap      = (pre_q == PW'(P - 1));
    // Expire on the wrap that takes count to zero, or at once for a zero duration
    assign expire    = (cnt_q == '0) || (wrap && cnt_q == TW'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    gnt_d   = 4'b0001 << win;
                    cnt_d   = dur[TW*int'(win) +: TW];
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (expire) begin
                    state_d = EXPIRE;
                    pre_d   = '0;
                    if (cnt_q != '0) cnt_d = cnt_q - TW'(1);
                end
`ifdef TICK_TIMER_ARB_ABORT_EN
                else if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    pre_d   = '0;
                    ptr_d   = own + 2'd1;
                end
`endif
                else if (wrap) begin
                    pre_d = '0;
                    cnt_d = cnt_q - TW'(1);
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            EXPIRE: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                pre_d   = '0;
                ptr_d   = own + 2'd1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = (state_q == EXPIRE) ? gnt_q : 4'b0000;
    assign busy      = |gnt_q;
    assign remaining = (state_q == IDLE) ? '0 : cnt_q;

    // Only consumed when the abort option is compiled in
    logic unused_ok;
    assign unused_ok = owner_req;

endmodule

// File: tb/tb_tick_timer_arb.sv
// Directed bench for tick_timer_arb with P = 10 cycles per tick.
module tb_tick_timer_arb;

    localparam int TW = 16;
    localparam int P  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [4*TW-1:0] dur;
    logic [3:0]    gnt, done;
    logic          busy;
    logic [TW-1:0] remaining;

    int checks = 0;
    int errors = 0;

    tick_timer_arb #(.CLK_HZ(100), .FREQ(10), .TW(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .dur(dur),
        .gnt(gnt), .done(done), .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       who;
        int       d;
        logic [3:0] exp_gnt;
        int       exp_lat;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        dur = '0;
        tick();
        rst = 1'b0;
    endtask

    // Wait for any grant; returns cycles spent
    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == 4'b0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n, output int extra_done);
        n = 0;
        extra_done = 0;
        while (done == 4'b0 && n < 500) begin
            tick();
            n++;
        end
    endtask

    int n, x, sawdone;

    initial begin
        vecs[0] = '{2, 3, 4'b0100, 30};
        vecs[1] = '{1, 0, 4'b0010, 1};
        vecs[2] = '{0, 1, 4'b0001, 10};
        vecs[3] = '{3, 2, 4'b1000, 20};

        do_reset();
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rem", int'(remaining), 0);

        // Single-requester grants with latency and remaining trace
        for (int v = 0; v < 4; v++) begin
            do_reset();
            dur[TW*vecs[v].who +: TW] = TW'(vecs[v].d);
            req = 4'b0001 << vecs[v].who;
            tick();
            chk("vec_gnt", int'(gnt), int'(vecs[v].exp_gnt));
            chk("vec_busy", int'(busy), 1);
            chk("vec_rem0", int'(remaining), vecs[v].d);
            dur = '1;
            n = 0;
            while (done == 4'b0 && n < 500) begin
                tick();
                n++;
                if (vecs[v].d > 0 && n % P == 0 && n < vecs[v].d * P)
                    chk("vec_rem_step", int'(remaining), vecs[v].d - n / P);
            end
            chk("vec_latency", n, vecs[v].exp_lat);
            chk("vec_done", int'(done), int'(vecs[v].exp_gnt));
            chk("vec_rem_end", int'(remaining), 0);
            req = '0;
            tick();
            chk("vec_gnt_clr", int'(gnt), 0);
            chk("vec_done_clr", int'(done), 0);
        end

        // All four requesting: strict rotation, one done per grant
        do_reset();
        dur = {16'd1, 16'd1, 16'd1, 16'd1};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n);
            chk("rr_gnt", int'(gnt), int'(4'b0001 << (k % 4)));
            wait_done(n, x);
            chk("rr_done", int'(done), int'(4'b0001 << (k % 4)));
            chk("rr_onehot", int'($onehot(gnt)), 1);
            tick();
            chk("rr_idle", int'(gnt), 0);
        end

        // Reset mid-run at count 2
        do_reset();
        dur[TW*3 +: TW] = 16'd4;
        req = 4'b1000;
        tick();
        n = 0;
        sawdone = 0;
        while (remaining != 16'd2 && n < 200) begin
            tick();
            n++;
            if (done != 0) sawdone++;
        end
        chk("mid_rem", int'(remaining), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_done", int'(done) + sawdone, 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_rem0", int'(remaining), 0);
        dur = {16'd1, 16'd1, 16'd1, 16'd1};
        req = 4'b1001;
        tick();
        chk("mid_ptr0", int'(gnt), 1);
        wait_done(n, x);
        req = 4'b1000;
        tick();
        tick();
        chk("mid_alone3", int'(gnt), 8);

        // Owner drops request at count 5 while requester 0 waits
        do_reset();
        dur[TW*2 +: TW] = 16'd7;
        dur[TW*0 +: TW] = 16'd1;
        req = 4'b0100;
        tick();
        chk("ab_gnt", int'(gnt), 4);
        req = 4'b0101;
        n = 0;
        while (remaining != 16'd5 && n < 200) begin
            tick();
            n++;
        end
        chk("ab_rem5", int'(remaining), 5);
        req = 4'b0001;
        tick();
`ifdef TICK_TIMER_ARB_ABORT_EN
        chk("ab_gnt_clr", int'(gnt), 0);
        chk("ab_no_done", int'(done), 0);
        tick();
        chk("ab_next", int'(gnt), 1);
`else
        chk("ab_keep", int'(gnt), 4);
        wait_done(n, x);
        chk("ab_done", int'(done), 4);
        tick();
        chk("ab_idle", int'(gnt), 0);
        tick();
        chk("ab_next", int'(gnt), 1);
`endif

        // Owner drop coincides with the expiry edge: expiry wins
        do_reset();
        dur[TW*1 +: TW] = 16'd1;
        req = 4'b0010;
        tick();
        chk("se_gnt", int'(gnt), 2);
        for (int k = 0; k < P - 1; k++) tick();
        chk("se_pre_done", int'(done), 0);
        req = 4'b0000;
        tick();
        chk("se_done", int'(done), 2);
        tick();
        chk("se_once", int'(done), 0);
        chk("se_idle", int'(gnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_timer_arb.md
TICK_TIMER_ARB -- requirements
Module: tick_timer_arb

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000; input clock frequency in Hz.
REQ-002 Parameter FREQ, default 1_000; timer tick frequency in Hz; tick period P = CLK_HZ/FREQ cycles, P >= 2.
REQ-003 Parameter TW, default 16; duration/count width in bits.
REQ-004 clk  input  1  system clock; the block has one clock.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  4  per-requester timer request, level.
REQ-007 dur  input  4*TW  packed durations in ticks; requester i at bits [TW*i+TW-1 : TW*i].
REQ-008 gnt  output  4  one-hot ownership of the shared timer; all-zero when free.
REQ-009 done  output  4  one-cycle expiry pulse to the owner.
REQ-010 busy  output  1  high whenever any gnt bit is high.
REQ-011 remaining  output  TW  current tick count of the running timer; 0 when idle.

Function
REQ-012 The block SHALL share one tick prescaler plus one TW-bit down-counter among 4 requesters.
REQ-013 FSM states SHALL be IDLE, RUN, EXPIRE.
REQ-014 IDLE: at a clock edge with any req bit high, the block SHALL select a winner round-robin, set gnt to that one-hot, load count = dur[winner], clear the prescaler, and enter RUN.
REQ-015 Round-robin: search order SHALL start at (last owner + 1) mod 4; the pointer SHALL be 0 after reset, so requester 0 has top priority.
REQ-016 dur SHALL be sampled only on the grant edge; later dur changes SHALL be ignored.
REQ-017 RUN: the prescaler SHALL count 0..P-1 and wrap; on each wrap, count SHALL decrement by 1.
REQ-018 When count reaches 0, the block SHALL enter EXPIRE; dur = 0 SHALL enter EXPIRE on the first RUN edge.
REQ-019 EXPIRE: done[owner] SHALL be high for exactly one cycle with gnt still asserted; the next edge SHALL clear gnt and return to IDLE.
REQ-020 Latency: with gnt first high in cycle 0, done SHALL be high in cycle D*P for D >= 1, and in cycle 1 for D = 0.
REQ-021 After EXPIRE, at least one IDLE cycle SHALL occur with gnt all-zero before the next grant.
REQ-022 An owner holding req high after done SHALL be re-eligible; the round-robin order alone determines who is granted next.
REQ-023 Count SHALL never underflow; remaining SHALL equal count in RUN/EXPIRE and 0 in IDLE.
REQ-024 Non-owner requests arriving during RUN SHALL wait; no request SHALL be lost while held high.

Reset
REQ-025 rst high at a clock edge SHALL force: state IDLE, gnt = 0, done = 0, busy = 0, remaining = 0, prescaler = 0, round-robin pointer = 0.
REQ-026 Reset mid-RUN SHALL abandon the timer without any done pulse; rst SHALL take precedence over all other events.

Configuration
REQ-027 Macro TICK_TIMER_ARB_ABORT_EN defined: in RUN, req[owner] low at a clock edge SHALL return to IDLE, clear gnt, emit no done, and advance the pointer past the owner.
REQ-028 If expiry and owner req drop occur on the same edge, expiry SHALL win and done SHALL pulse.
REQ-029 Macro TICK_TIMER_ARB_ABORT_EN undefined: req drops during RUN SHALL be ignored and the timer SHALL run to done.

Verification
REQ-030 CLK_HZ=100, FREQ=10 (P=10); req[2]=1, dur[2]=3 -> gnt=0100 next cycle; done[2] high exactly 30 cycles after gnt rise; remaining steps 3,2,1,0.
REQ-031 req=1111 all held, dur=1 each -> grant order 0,1,2,3,0; one done per grant; gnt always one-hot.
REQ-032 req[1]=1, dur[1]=0 -> done[1] one cycle after gnt rise; next cycle gnt=0000.
REQ-033 rst pulsed at count=2 in RUN -> next cycle all outputs 0; no done; subsequent req[3] granted before req[0..2] only if alone.
REQ-034 With ABORT_EN: owner drops req at count=5 -> gnt=0 next cycle, no done; waiting req[0] granted after one IDLE cycle. Without ABORT_EN: same stimulus -> done still pulses.
REQ-035 Owner drops req on the same edge as expiry (ABORT_EN) -> done pulses once.
